// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter output instret: define MULTICYCLE_CTRL_INSTRET_EN.
module multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 16,
    parameter int WAIT_CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halt,
    output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    // state  | meaning
    // RST    | idle after reset, leaves next cycle
    // FETCH  | read instruction at PC, load IR on mem_ready
    // DECODE | classify opcode, illegal/system goes to TRAP
    // EXEC   | ALU operation; branches and FENCE finish here
    // MEM    | load/store access at ALU address
    // WB     | register write and PC update
    // TRAP   | halted until reset
    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam bit                   TIMEOUT_EN = (MEM_WAIT_MAX != 0);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

    state_t                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic                    waiting;
    logic                    timeout;

    // wait_cnt holds the stalled cycles already spent; this cycle is the last allowed one
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign timeout = TIMEOUT_EN && waiting && (wait_cnt == WAIT_LAST);
    assign state   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RST;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        halt      = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG,
                    OP_LOAD, OP_STORE, OP_BRANCH, OP_FENCE: state_d = S_EXEC;
                    default:                                state_d = S_TRAP;
                endcase
            end
            S_EXEC: begin
                alu_a_sel = (opcode == OP_AUIPC) || (opcode == OP_JAL) || (opcode == OP_BRANCH);
                alu_b_sel = !((opcode == OP_REG) || (opcode == OP_BRANCH));
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? 2'd1 : 2'd0;
                        state_d = S_FETCH;
                    end
                    OP_FENCE: begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
                case (opcode)
                    OP_LOAD: wb_sel = 2'd1;
                    OP_JAL:  begin wb_sel = 2'd2; pc_sel = 2'd1; end
                    OP_JALR: begin wb_sel = 2'd2; pc_sel = 2'd2; end
                    OP_LUI:  wb_sel = 2'd3;
                    default: wb_sel = 2'd0;
                endcase
            end
            S_TRAP: halt = 1'b1;
            default: state_d = S_RST;
        endcase
    end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic retire;
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instret <= 32'd0;
        else if (retire)
            instret <= instret + 32'd1;
    end
`endif

endmodule
